// File: rtl/mbe_pp_gen.sv
// Radix-4 Booth partial-product rows + sign-correction bits for the Dadda tree; MBE_PP_GEN_SKID_EN adds a skid entry.
// Latency: 1 cycle from accept to out_valid; 1 transfer/cycle under continuous out_ready.
// Backpressure: outputs hold while out_valid && !out_ready; in_ready is combinational (base) or registered (skid).
module mbe_pp_gen #(
    parameter  int WIDTH = 11,
    localparam int ROWS  = (WIDTH + 2) / 2,
    localparam int ROW_W = WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a_i,
    input  logic [WIDTH-1:0]      b_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROWS*ROW_W-1:0] pp_o,
    output logic [ROWS-2:0]       signs_o
);

    logic [WIDTH+1:0]       b_ext;
    logic [ROWS-1:0]        neg;
    logic [WIDTH:0]         mag [ROWS];
    logic [ROWS*ROW_W-1:0]  pp_d;
    logic [ROWS-2:0]        signs_d;

    // Booth recoding of overlapping triplets; negative digits use one's complement,
    // the missing +1 travels on signs_o.
    always_comb begin
        b_ext = {1'b0, b_i, 1'b0};
        neg   = '0;
        pp_d  = '0;
        for (int r = 0; r < ROWS; r++) begin
            mag[r] = '0;
            case (b_ext[2*r +: 3])
                3'b001, 3'b010: mag[r] = {1'b0, a_i};
                3'b011:         mag[r] = {a_i, 1'b0};
                3'b100: begin
                    mag[r] = {a_i, 1'b0};
                    neg[r] = 1'b1;
                end
                3'b101, 3'b110: begin
                    mag[r] = {1'b0, a_i};
                    neg[r] = 1'b1;
                end
                default:        mag[r] = '0;
            endcase
            if (neg[r]) begin
                mag[r] = ~mag[r];
            end
            if (r == 0) begin
                pp_d[r*ROW_W +: ROW_W] = {~neg[r], neg[r], neg[r], mag[r]};
            end else begin
                pp_d[r*ROW_W +: ROW_W] = {1'b0, 1'b1, ~neg[r], mag[r]};
            end
        end
    end

    assign signs_d = neg[ROWS-2:0];

    logic [ROWS*ROW_W-1:0] pp_q;
    logic [ROWS-2:0]       signs_q;

    assign pp_o    = pp_q;
    assign signs_o = signs_q;

`ifdef MBE_PP_GEN_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t                state, state_nxt;
    logic                  load_main, load_skid, skid_to_main;
    logic                  in_ready_q;
    logic [ROWS*ROW_W-1:0] skid_pp;
    logic [ROWS-2:0]       skid_signs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    load_main = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        load_main = 1'b1;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end else if (in_valid) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end
            end
            TWO: begin
                if (out_ready) begin
                    skid_to_main = 1'b1;
                    state_nxt    = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_q       <= '0;
            signs_q    <= '0;
            skid_pp    <= '0;
            skid_signs <= '0;
        end else begin
            if (load_main) begin
                pp_q    <= pp_d;
                signs_q <= signs_d;
            end else if (skid_to_main) begin
                pp_q    <= skid_pp;
                signs_q <= skid_signs;
            end
            if (load_skid) begin
                skid_pp    <= pp_d;
                skid_signs <= signs_d;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
`else
    typedef enum logic {EMPTY, FULL} state_t;

    state_t state, state_nxt;
    logic   load_main;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        in_ready  = (state == EMPTY) || out_ready;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    load_main = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (in_valid) begin
                        load_main = 1'b1;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_q    <= '0;
            signs_q <= '0;
        end else if (load_main) begin
            pp_q    <= pp_d;
            signs_q <= signs_d;
        end
    end

    assign out_valid = (state == FULL);
`endif

endmodule

// File: tb/tb_mbe_pp_gen.sv
// Bench for mbe_pp_gen: directed corner operands, backpressure, streaming and async reset,
// checked against an arithmetic Booth-digit model and a*b reconstruction.
module tb_mbe_pp_gen;

    localparam int WIDTH = 11;
    localparam int ROWS  = 6;
    localparam int ROW_W = 15;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [WIDTH-1:0]      a_i = '0;
    logic [WIDTH-1:0]      b_i = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [ROWS*ROW_W-1:0] pp_o;
    logic [ROWS-2:0]       signs_o;

    int n_vec = 0;
    int n_err = 0;

    logic [2*WIDTH-1:0] exp_q[$];

    mbe_pp_gen #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp_o      (pp_o),
        .signs_o   (signs_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Booth digit d = b[2r-1] + b[2r] - 2*b[2r+1] evaluated with integers.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [ROWS*ROW_W-1:0] pp, output logic [ROWS-2:0] sg);
        int          bx;
        int          d;
        logic [11:0] m;
        logic        n;
        bx = int'(b) << 1;
        pp = '0;
        sg = '0;
        for (int r = 0; r < ROWS; r++) begin
            d = ((bx >> (2*r)) & 1) + ((bx >> (2*r+1)) & 1) - 2 * ((bx >> (2*r+2)) & 1);
            n = (d < 0);
            m = 12'(((d < 0) ? -d : d) * int'(a));
            if (n) m = ~m;
            if (r == 0) pp[r*ROW_W +: ROW_W] = {~n, n, n, m};
            else        pp[r*ROW_W +: ROW_W] = {1'b0, 1'b1, ~n, m};
            if (r < ROWS - 1) sg[r] = n;
        end
    endfunction

    function automatic logic [2*WIDTH-1:0] recon(input logic [ROWS*ROW_W-1:0] pp, input logic [ROWS-2:0] sg);
        logic [31:0] s;
        s = '0;
        for (int r = 0; r < ROWS; r++) s = s + (32'(pp[r*ROW_W +: ROW_W]) << (2*r));
        for (int r = 0; r < ROWS - 1; r++) s = s + (32'(sg[r]) << (2*r));
        return s[2*WIDTH-1:0];
    endfunction

    // One clock: drive at negedge, sample 1ns later, well away from the rising edge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ordy);
        logic [ROWS*ROW_W-1:0] epp;
        logic [ROWS-2:0]       esg;
        logic [2*WIDTH-1:0]    pair;
        logic [WIDTH-1:0]      pa, pb;
        logic                  acc, drn, exp_rdy;
        @(negedge clk);
        in_valid  = iv;
        a_i       = a;
        b_i       = b;
        out_ready = ordy;
        #1;
`ifdef MBE_PP_GEN_SKID_EN
        exp_rdy = (exp_q.size() < 2);
`else
        exp_rdy = (exp_q.size() == 0) || ordy;
`endif
        check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (drn && exp_q.size() != 0) begin
            pair = exp_q.pop_front();
            pa   = pair[2*WIDTH-1:WIDTH];
            pb   = pair[WIDTH-1:0];
            model(pa, pb, epp, esg);
            check("pp_rows", 128'(pp_o), 128'(epp));
            check("signs", 128'(signs_o), 128'(esg));
            check("product", 128'(recon(pp_o, signs_o)), 128'(32'(pa) * 32'(pb)));
        end
        if (acc) exp_q.push_back({a, b});
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_pp", 128'(pp_o), 128'(0));
        check("rst_signs", 128'(signs_o), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 11'h7FF, 11'h7FF, 1'b1);
        step(1'b1, 11'h123, 11'h000, 1'b1);
        step(1'b1, 11'h400, 11'h555, 1'b1);
        step(1'b1, 11'h400, 11'h2AA, 1'b1);
        step(1'b1, 11'h000, 11'h5A5, 1'b1);
        step(1'b1, 11'h7FF, 11'h400, 1'b1);
        step(1'b0, 11'h000, 11'h000, 1'b1);
        step(1'b0, 11'h000, 11'h000, 1'b1);

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 11'($urandom), 11'($urandom), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 11'h000, 11'h000, 1'b1);
        end

        for (int i = 0; i < 20; i++) begin
            step(1'b1, 11'($urandom), 11'($urandom), 1'b1);
        end

        for (int i = 0; i < 1000; i++) begin
            ra = 11'($urandom);
            rb = 11'($urandom);
            step(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 3) != 0));
        end

        step(1'b1, 11'h3C3, 11'h2F1, 1'b0);
        step(1'b1, 11'h1AB, 11'h7E0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_pp", 128'(pp_o), 128'(0));
        check("mid_rst_signs", 128'(signs_o), 128'(0));
        check("mid_rst_in_ready", 128'(in_ready), 128'(1));
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 11'h5A5, 11'h3FF, 1'b1);
        step(1'b1, 11'h001, 11'h7FF, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            step(1'b0, 11'h000, 11'h000, 1'b1);
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
